req_sync_arbiter: RTL

REQ_SYNC_ARBITER -- requirements
Module: req_sync_arbiter

---
 rtl/sync_pkg.sv | 6 +
 rtl/sync.sv | 15 +
 rtl/req_sync_arbiter.sv | 77 +++++++
 3 files changed

// File: rtl/sync_pkg.sv
// sync_pkg: shared FSM state encoding and default sizing for the request synchronizer/arbiter.
package sync_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/sync.sv
// sync: multi-flop synchronizer for one asynchronous level line.
module sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/req_sync_arbiter.sv
// req_sync_arbiter: synchronizes asynchronous request lines, latches rising edges as pending
// requests and grants them one at a time in round-robin order with a valid/ready handshake.
module req_sync_arbiter
  import sync_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] async_req,
  input  logic               grant_ready,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic [NUM_REQ-1:0] pending,
  output logic               drop_err
);
  logic [NUM_REQ-1:0] s, prev, armed, ev, clr, rot, pend_next;
  logic [2*NUM_REQ-1:0] dbl;
  logic [1:0] settle;
  logic settled, hs;
  logic [IDW-1:0] rr_ptr, rr_next, id_next, off, sel;
  logic [IDW:0] sum;
  state_t state, state_next;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
    sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .n_rst(n_rst), .d(async_req[i]), .q(s[i]));
  end
  // A line only arms once the flushed synchronizer has shown it low, so lines held high through reset stay silent.
  assign settled = settle == 2'(SYNC_STAGES);
  assign ev = s & ~prev & armed;
  assign grant_valid = state == GRANT;
  assign hs = grant_valid & grant_ready;
  assign clr = hs ? NUM_REQ'(1) << grant_id : '0;
  assign pend_next = (pending & ~clr) | ev;
  assign dbl = {pending, pending} >> rr_ptr;
  assign rot = dbl[NUM_REQ-1:0];
  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = IDW'(k);
  end
  assign sum = {1'b0, rr_ptr} + {1'b0, off};
  assign sel = sum >= (IDW+1)'(NUM_REQ) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : sum[IDW-1:0];
  always_comb begin
    state_next = state;
    id_next = grant_id;
    rr_next = rr_ptr;
    if (state == IDLE && |pending) begin
      state_next = GRANT;
      id_next = sel;
    end else if (hs) begin
      state_next = IDLE;
      id_next = '0;
      rr_next = grant_id == IDW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      pending <= '0;
      drop_err <= 1'b0;
      prev <= '0;
      armed <= '0;
      settle <= '0;
    end else begin
      state <= state_next;
      grant_id <= id_next;
      rr_ptr <= rr_next;
      pending <= pend_next;
      drop_err <= |(ev & pending & ~clr);
      prev <= s;
      armed <= armed | ({NUM_REQ{settled}} & ~s);
      if (!settled) settle <= settle + 2'd1;
    end
endmodule
